// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write bypass, hardwired x0, a post-reset
// clear engine and per-register pending bits for operand stalls.
module reg_file_mp #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_X0 = 1,
    parameter int unsigned BYPASS  = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_pend,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                ready
);

    localparam logic StInit = 1'b0;
    localparam logic StRun  = 1'b1;

    logic            state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic run;
    logic wr_ok;
    logic rsv_ok;

    assign run   = (state_q == StRun);
    assign ready = run;

    always_comb begin
        wr_ok  = run && we && !((ZERO_X0 != 0) && (wa == '0));
        rsv_ok = run && rsv_en && !((ZERO_X0 != 0) && (rsv_addr == '0));
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!run) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(NREGS - 1)) begin
                state_d = StRun;
            end
        end
    end

    // Reserve is applied after the write so it wins on a same-register collision.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wa] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            clr_cnt_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pend_q    <= pend_d;
        end
    end

    // Storage has no reset; the clear engine defines every entry before RUN.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[wa] <= wd;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            port_pend;

        assign addr = ra[g*AW +: AW];

        always_comb begin
            data      = '0;
            port_pend = 1'b0;
            if (run && !((ZERO_X0 != 0) && (addr == '0))) begin
                if ((BYPASS != 0) && wr_ok && (wa == addr)) begin
                    data = wd;
                end else begin
                    data      = mem_q[addr];
                    port_pend = pend_q[addr];
                end
            end
        end

        assign rd[g*XLEN +: XLEN] = data;
        assign rd_pend[g]         = port_pend;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: table-driven RUN vectors plus reset/clear sequences,
// checked through an expectation queue. A BYPASS=0 instance shares the inputs.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra0, ra1;
    logic [9:0]  ra;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  pend_a, pend_b;
    logic        we, rsv_en;
    logic [4:0]  wa, rsv_addr;
    logic [31:0] wd;
    logic        ready_a, ready_b;

    int total = 0;
    int bad   = 0;

    assign ra = {ra1, ra0};

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_a), .rd_pend(pend_a),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .ready(ready_a)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_pend(pend_b),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .ready(ready_b)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  raddr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ep0;
        logic        ep1;
        logic [31:0] n1;
        logic        np1;
    } vec_t;

    vec_t tbl[19];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return rd_a[31:0];
            1:       return rd_a[63:32];
            2:       return {31'd0, pend_a[0]};
            3:       return {31'd0, pend_a[1]};
            4:       return rd_b[63:32];
            5:       return {31'd0, pend_b[1]};
            6:       return {31'd0, ready_a};
            7:       return {31'd0, ready_b};
            default: return rd_b[31:0];
        endcase
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp(e.name, actual(e.sel), e.exp);
        end
    endtask

    task automatic idle_inputs();
        we       = 1'b0;
        wa       = '0;
        wd       = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    // Counts clock edges from now until both instances report ready.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!(ready_a && ready_b) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp(name, 32'(n), 32'd32);
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            ra1 = 5'(31 - a);
            #1;
            push($sformatf("%s_rd0_a%0d", tag, a), 0, 32'd0);
            push($sformatf("%s_p0_a%0d", tag, a), 2, 32'd0);
            push($sformatf("%s_nbrd1_a%0d", tag, 31 - a), 4, 32'd0);
            drain();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           we wa    wd            rsv ra   ra0 ra1 e0            e1            ep ep n1            np
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0,        0};
        tbl[1]  = '{0, 0,  32'h0,        0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0};
        tbl[2]  = '{1, 0,  32'h12345678, 1, 0,  0,  5,  32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0};
        tbl[3]  = '{0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0};
        tbl[4]  = '{1, 7,  32'h1,        0, 0,  7,  3,  32'h1,        32'h0,        0, 0, 32'h0,        0};
        tbl[5]  = '{1, 7,  32'hA5A5A5A5, 0, 0,  5,  7,  32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'h1,        0};
        tbl[6]  = '{0, 0,  32'h0,        0, 0,  7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0};
        tbl[7]  = '{0, 0,  32'h0,        1, 3,  3,  3,  32'h0,        32'h0,        0, 0, 32'h0,        0};
        tbl[8]  = '{0, 0,  32'h0,        0, 0,  3,  5,  32'h0,        32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0};
        tbl[9]  = '{1, 3,  32'h55,       0, 0,  3,  3,  32'h55,       32'h55,       0, 0, 32'h0,        1};
        tbl[10] = '{0, 0,  32'h0,        0, 0,  3,  3,  32'h55,       32'h55,       0, 0, 32'h55,       0};
        tbl[11] = '{1, 3,  32'h66,       1, 3,  3,  7,  32'h66,       32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0};
        tbl[12] = '{0, 0,  32'h0,        0, 0,  3,  3,  32'h66,       32'h66,       1, 1, 32'h66,       1};
        tbl[13] = '{1, 30, 32'hFFFFFFFF, 1, 31, 31, 30, 32'h0,        32'hFFFFFFFF, 0, 0, 32'h0,        0};
        tbl[14] = '{0, 0,  32'h0,        0, 0,  31, 30, 32'h0,        32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0};
        tbl[15] = '{1, 31, 32'hCAFEF00D, 0, 0,  31, 31, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 32'h0,        1};
        tbl[16] = '{0, 0,  32'h0,        0, 0,  31, 31, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0};
        tbl[17] = '{0, 0,  32'h0,        1, 9,  9,  3,  32'h0,        32'h66,       0, 1, 32'h66,       1};
        tbl[18] = '{0, 0,  32'h0,        0, 0,  9,  3,  32'h0,        32'h66,       1, 1, 32'h66,       1};

        rst_n = 1'b0;
        idle_inputs();
        ra0 = 5'd31;
        ra1 = 5'd0;
        #1;
        push("por_ready", 6, 32'd0);
        push("por_pend0", 2, 32'd0);
        drain();

        // Abort the first clear at clr_cnt=10, then expect a full restart.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push("init_rd0_uncleared", 0, 32'd0);
        push("init_ready", 6, 32'd0);
        drain();
        repeat (9) @(posedge clk);
        #1;
        push("midclr_ready_before", 6, 32'd0);
        drain();
        rst_n = 1'b0;
        #1;
        push("midclr_ready_rst", 6, 32'd0);
        drain();
        #2;
        rst_n = 1'b1;
        wait_ready("clear_cycles_restart");
        push("nb_ready", 7, 32'd1);
        drain();
        check_all_zero("rst1");

        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            we       = tbl[i].we;
            wa       = tbl[i].wa;
            wd       = tbl[i].wd;
            rsv_en   = tbl[i].rsv;
            rsv_addr = tbl[i].raddr;
            ra0      = tbl[i].ra0;
            ra1      = tbl[i].ra1;
            push($sformatf("v%0d_rd0", i), 0, tbl[i].e0);
            push($sformatf("v%0d_rd1", i), 1, tbl[i].e1);
            push($sformatf("v%0d_p0", i), 2, {31'd0, tbl[i].ep0});
            push($sformatf("v%0d_p1", i), 3, {31'd0, tbl[i].ep1});
            push($sformatf("v%0d_nb_rd1", i), 4, tbl[i].n1);
            push($sformatf("v%0d_nb_p1", i), 5, {31'd0, tbl[i].np1});
            #3;
            drain();
        end

        // Reset in RUN with pend3/pend9 set must clear outputs without a clock edge.
        @(posedge clk);
        #1;
        idle_inputs();
        ra0 = 5'd3;
        ra1 = 5'd9;
        #1;
        push("run_p0_before", 2, 32'd1);
        push("run_p1_before", 3, 32'd1);
        push("run_ready_before", 6, 32'd1);
        drain();
        rst_n = 1'b0;
        #1;
        push("run_rst_p0", 2, 32'd0);
        push("run_rst_p1", 3, 32'd0);
        push("run_rst_ready", 6, 32'd0);
        push("run_rst_nb_ready", 7, 32'd0);
        push("run_rst_rd0", 0, 32'd0);
        drain();
        #1;
        rst_n = 1'b1;
        wait_ready("clear_cycles_run_rst");
        check_all_zero("rst2");

        // x0 stays zero/not pending across later cycles.
        @(posedge clk);
        #1;
        we       = 1'b1;
        wa       = 5'd0;
        wd       = 32'h12345678;
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        ra0      = 5'd0;
        @(posedge clk);
        #1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            push($sformatf("x0_rd_c%0d", k), 0, 32'd0);
            push($sformatf("x0_p_c%0d", k), 2, 32'd0);
            push($sformatf("x0_nb_rd_c%0d", k), 8, 32'd0);
            drain();
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
